// File: rtl/jtag_uart_bridge_pkg.sv
// Shared types and register-map constants for the JTAG UART bridge.
package jtag_uart_pkg;

  typedef enum logic [1:0] {
    ST_POLL  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  localparam logic [2:0]  ADDR_CTRL  = 3'd4;
  localparam logic [2:0]  ADDR_DATA  = 3'd0;
  localparam int unsigned WSPACE_LSB = 16;
  localparam int unsigned WSPACE_MSB = 31;
  localparam int unsigned RVALID_BIT = 15;
  localparam int unsigned CREDIT_W   = 16;
  localparam int unsigned BYTE_W     = 8;

  function automatic logic [CREDIT_W-1:0] wspace_of(input logic [31:0] rd);
    return rd[WSPACE_MSB:WSPACE_LSB];
  endfunction

  function automatic logic [2:0] addr_of(input state_t s);
    return (s == ST_POLL) ? ADDR_CTRL : ADDR_DATA;
  endfunction

endpackage

// File: rtl/jtag_uart_bridge_if.sv
// Avalon-MM port towards the JTAG UART slave.
interface jtag_uart_bridge_if;
  logic [2:0]  jtag_address;
  logic        jtag_read;
  logic        jtag_write;
  logic [31:0] jtag_writedata;
  logic        jtag_waitrequest;
  logic [31:0] jtag_readdata;

  modport master (
    output jtag_address, jtag_read, jtag_write, jtag_writedata,
    input  jtag_waitrequest, jtag_readdata
  );

  modport slave (
    input  jtag_address, jtag_read, jtag_write, jtag_writedata,
    output jtag_waitrequest, jtag_readdata
  );
endinterface

// File: rtl/jtag_uart_bridge_byte_fifo.sv
// Byte FIFO with valid/ready on both sides; a pop frees a slot for a same-cycle push.
module byte_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_s_valid,
  output logic          o_s_ready,
  input  logic [7:0]    i_s_data,
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic [7:0]    o_m_data,
  output logic [CW-1:0] o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_full    = (r_count == CW'(DEPTH));
  assign o_m_valid = (r_count != '0);
  assign o_s_ready = !w_full;
  assign w_pop     = i_m_ready && o_m_valid;
  assign w_push    = i_s_valid && (!w_full || w_pop);
  assign o_m_data  = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= i_s_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jtag_uart_bridge.sv
// Bridges fabric byte streams to a JTAG UART over Avalon-MM: polls WSPACE, drains TX, fetches RX.
module jtag_uart_bridge
  import jtag_uart_pkg::*;
#(
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16,
  parameter int unsigned ENABLE_RX = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tx_valid,
  input  logic [7:0]         tx_data,
  output logic               tx_ready,
  output logic               rx_valid,
  output logic [7:0]         rx_data,
  input  logic               rx_ready,
  jtag_uart_bridge_if.master jtag
);

  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
  localparam bit          RX_ON = (ENABLE_RX != 0);

  state_t              r_state;
  state_t              w_next;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_read;
  logic                r_write;
  logic [2:0]          r_address;

  logic             w_accept;
  logic             w_tx_s_ready, w_tx_push, w_tx_pop, w_tx_m_valid, w_tx_left_nz;
  logic [7:0]       w_tx_head;
  logic [TX_CW-1:0] w_tx_count;
  logic             w_rx_s_ready, w_rx_push, w_rx_m_valid, w_rx_ok;
  logic [7:0]       w_rx_head;
  logic [RX_CW-1:0] w_rx_count;
  logic             w_unused;

  assign w_accept     = !jtag.jtag_waitrequest;
  assign w_tx_push    = tx_valid && w_tx_s_ready;
  assign w_tx_pop     = (r_state == ST_WRITE) && w_accept;
  assign w_tx_left_nz = (w_tx_count > TX_CW'(1)) || w_tx_push;
  assign w_rx_push    = RX_ON && (r_state == ST_RDATA) && w_accept
                        && jtag.jtag_readdata[RVALID_BIT];
  assign w_rx_ok      = RX_ON && w_rx_s_ready;
  assign w_unused     = &{1'b0, jtag.jtag_readdata[14:8], w_rx_count};

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clock     (clock),
    .reset     (reset),
    .i_s_valid (w_tx_push),
    .o_s_ready (w_tx_s_ready),
    .i_s_data  (tx_data),
    .o_m_valid (w_tx_m_valid),
    .i_m_ready (w_tx_pop),
    .o_m_data  (w_tx_head),
    .o_count   (w_tx_count)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clock     (clock),
    .reset     (reset),
    .i_s_valid (w_rx_push),
    .o_s_ready (w_rx_s_ready),
    .i_s_data  (jtag.jtag_readdata[7:0]),
    .o_m_valid (w_rx_m_valid),
    .i_m_ready (RX_ON && rx_ready),
    .o_m_data  (w_rx_head),
    .o_count   (w_rx_count)
  );

  // Next state only moves on an accepted transfer, which keeps the bus frozen during stalls.
  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      case (r_state)
        ST_POLL:
          if ((wspace_of(jtag.jtag_readdata) != '0) && w_tx_m_valid) w_next = ST_WRITE;
          else if (w_rx_ok)                                         w_next = ST_RDATA;
          else                                                      w_next = ST_POLL;
        ST_WRITE:
          if ((r_credit != CREDIT_W'(1)) && w_tx_left_nz) w_next = ST_WRITE;
          else if (w_rx_ok)                              w_next = ST_RDATA;
          else                                           w_next = ST_POLL;
        default: w_next = ST_POLL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_POLL;
      r_credit  <= '0;
      r_read    <= 1'b1;
      r_write   <= 1'b0;
      r_address <= ADDR_CTRL;
    end else begin
      r_state   <= w_next;
      r_read    <= (w_next != ST_WRITE);
      r_write   <= (w_next == ST_WRITE);
      r_address <= addr_of(w_next);
      if (w_accept) begin
        case (r_state)
          ST_POLL:  r_credit <= wspace_of(jtag.jtag_readdata);
          ST_WRITE: if (r_credit != '0) r_credit <= r_credit - CREDIT_W'(1);
          default:  r_credit <= r_credit;
        endcase
      end
    end
  end

  assign jtag.jtag_address   = r_address;
  assign jtag.jtag_read      = r_read;
  assign jtag.jtag_write     = r_write;
  assign jtag.jtag_writedata = {24'd0, r_write ? w_tx_head : 8'd0};

  assign tx_ready = w_tx_s_ready;
  assign rx_valid = RX_ON && w_rx_m_valid;
  assign rx_data  = rx_valid ? w_rx_head : 8'd0;

endmodule

// File: tb/tb_jtag_uart_bridge.sv
// Directed bench for jtag_uart_bridge with a behavioural JTAG UART slave.
module tb_jtag_uart_bridge;
  import jtag_uart_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0] tx_data, rx_data;

  logic [15:0] wspace;
  logic [31:0] rd_word;
  logic        wait_r;

  jtag_uart_bridge_if jif ();

  assign jif.jtag_waitrequest = wait_r;
  assign jif.jtag_readdata    = (jif.jtag_address == ADDR_CTRL) ? {wspace, 16'h0000} : rd_word;

  jtag_uart_bridge #(.TX_DEPTH(16), .RX_DEPTH(16), .ENABLE_RX(1)) dut (
    .clock    (clock),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .jtag     (jif)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] wr_log[$];
  int         poll_acc  = 0;
  int         rdata_acc = 0;
  int         rdata_cyc = 0;

  // Slave-side monitor: records accepted writes and counts read transfers.
  always @(posedge clock) begin
    if (!reset) begin
      if (jif.jtag_write && !jif.jtag_waitrequest) wr_log.push_back(jif.jtag_writedata[7:0]);
      if (jif.jtag_read && !jif.jtag_waitrequest && jif.jtag_address == ADDR_CTRL) poll_acc++;
      if (jif.jtag_read && !jif.jtag_waitrequest && jif.jtag_address == ADDR_DATA) rdata_acc++;
      if (jif.jtag_read && jif.jtag_address == ADDR_DATA) rdata_cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && wr_log.size() < n; i++) @(negedge clock);
  endtask

  task automatic wait_rdata(input int target, input int budget);
    for (int i = 0; i < budget && rdata_acc < target; i++) @(negedge clock);
  endtask

  task automatic wait_write_strobe(input int budget);
    for (int i = 0; i < budget && !jif.jtag_write; i++) @(negedge clock);
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  initial begin
    int p0, r0, c0;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    wspace = 16'd0; rd_word = 32'd0; wait_r = 1'b1;
    step(3);
    check("rst_read",   32'(jif.jtag_read), 32'd1);
    check("rst_addr",   32'(jif.jtag_address), 32'd4);
    check("rst_write",  32'(jif.jtag_write), 32'd0);
    check("rst_wdata",  jif.jtag_writedata, 32'd0);
    check("rst_txrdy",  32'(tx_ready), 32'd1);
    check("rst_rxvld",  32'(rx_valid), 32'd0);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    check("rst_credit", 32'(dut.r_credit), 32'd0);
    reset = 1'b0;

    // Three bytes, ample space, no stalls.
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    p0 = poll_acc;
    wspace = 16'd64; wait_r = 1'b0;
    wait_writes(3, 50);
    check("t1_nwr",    32'(wr_log.size()), 32'd3);
    check("t1_credit", 32'(dut.r_credit), 32'd61);
    check("t1_polls",  32'(poll_acc - p0), 32'd1);
    check("t1_b0", 32'(wr_log[0]), 32'h41);
    check("t1_b1", 32'(wr_log[1]), 32'h42);
    check("t1_b2", 32'(wr_log[2]), 32'h43);
    wr_log.delete();

    // Credit limited to two writes, remainder after fresh space.
    wait_r = 1'b1; wspace = 16'd2;
    for (int k = 0; k < 5; k++) push_byte(8'(8'h10 + k));
    wait_r = 1'b0;
    wait_writes(2, 50);
    wspace = 16'd0;
    check("t2_nwr2",   32'(wr_log.size()), 32'd2);
    check("t2_credit", 32'(dut.r_credit), 32'd0);
    step(12);
    check("t2_hold",   32'(wr_log.size()), 32'd2);
    wspace = 16'd3;
    wait_writes(5, 50);
    check("t2_nwr5", 32'(wr_log.size()), 32'd5);
    for (int k = 0; k < 5; k++) check("t2_order", 32'(wr_log[k]), 32'(8'h10 + k));
    wr_log.delete();
    wspace = 16'd64;

    // Stalled write of 0x55 holds the bus and pops once.
    wait_r = 1'b1;
    push_byte(8'h55);
    wait_r = 1'b0;
    wait_write_strobe(50);
    wait_r = 1'b1;
    check("t3_strobe", 32'(jif.jtag_write), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_wr",   32'(jif.jtag_write), 32'd1);
      check("t3_hold_addr", 32'(jif.jtag_address), 32'd0);
      check("t3_hold_data", jif.jtag_writedata, 32'h55);
      check("t3_no_acc",    32'(wr_log.size()), 32'd0);
      @(negedge clock);
    end
    wait_r = 1'b0;
    wait_writes(1, 20);
    step(10);
    check("t3_nwr",  32'(wr_log.size()), 32'd1);
    check("t3_byte", 32'(wr_log[0]), 32'h55);
    wr_log.delete();
    wspace = 16'd0;

    // One valid read then an invalid one.
    rd_word = 32'h0000_8061;
    r0 = rdata_acc;
    wait_rdata(r0 + 1, 50);
    rd_word = 32'd0;
    check("t4_rxvld", 32'(rx_valid), 32'd1);
    check("t4_rxdat", 32'(rx_data), 32'h61);
    wait_rdata(r0 + 2, 50);
    check("t4_nrd",    32'(rdata_acc - r0), 32'd2);
    check("t4_rxvld2", 32'(rx_valid), 32'd1);
    pop_rx();
    check("t4_empty",  32'(rx_valid), 32'd0);

    // Fill RX, verify reads stop until a slot frees.
    for (int k = 0; k < 16; k++) begin
      rd_word = 32'h0000_8000 | 32'(k);
      r0 = rdata_acc;
      wait_rdata(r0 + 1, 50);
    end
    rd_word = 32'h0000_80AA;
    r0 = rdata_acc; c0 = rdata_cyc;
    step(20);
    check("t5_no_rd",  32'(rdata_acc - r0), 32'd0);
    check("t5_no_cyc", 32'(rdata_cyc - c0), 32'd0);
    check("t5_head",   32'(rx_data), 32'h00);
    pop_rx();
    wait_rdata(r0 + 1, 20);
    rd_word = 32'd0;
    check("t5_resume", 32'(rdata_acc - r0), 32'd1);
    for (int k = 1; k < 16; k++) begin
      check("t5_order", 32'(rx_data), 32'(k));
      pop_rx();
    end
    check("t5_last", 32'(rx_data), 32'hAA);

    // Reset in the middle of a stalled write with bytes queued.
    wait_r = 1'b1; wspace = 16'd64;
    for (int k = 0; k < 4; k++) push_byte(8'(8'h60 + k));
    wait_r = 1'b0;
    wait_write_strobe(50);
    wait_r = 1'b1;
    check("t6_inwr", 32'(jif.jtag_write), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t6_state", 32'(dut.r_state), 32'(ST_POLL));
    check("t6_read",  32'(jif.jtag_read), 32'd1);
    check("t6_addr",  32'(jif.jtag_address), 32'd4);
    check("t6_write", 32'(jif.jtag_write), 32'd0);
    check("t6_txrdy", 32'(tx_ready), 32'd1);
    check("t6_rxvld", 32'(rx_valid), 32'd0);
    check("t6_wdata", jif.jtag_writedata, 32'd0);
    reset = 1'b0; wait_r = 1'b0;
    step(20);
    check("t6_nwr", 32'(wr_log.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jtag_uart_bridge.md
JTAG_UART_BRIDGE -- requirements
Module: jtag_uart_bridge

Interface
REQ-001 Parameter TX_DEPTH, default 16, TX byte FIFO depth; power of two, >=2.
REQ-002 Parameter RX_DEPTH, default 16, RX byte FIFO depth; power of two, >=2.
REQ-003 Parameter ENABLE_RX, default 1, 1 = host-to-fabric path active, 0 = TX only.
REQ-004 clock  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 tx_valid  in  1  fabric offers byte.
REQ-007 tx_data  in  8  byte offered.
REQ-008 tx_ready  out  1  TX FIFO not full; transfer on tx_valid && tx_ready.
REQ-009 rx_valid  out  1  RX FIFO not empty.
REQ-010 rx_data  out  8  RX FIFO head.
REQ-011 rx_ready  in  1  fabric pops; transfer on rx_valid && rx_ready.
REQ-012 jtag_address  out  3  4 = control register, 0 = data register.
REQ-013 jtag_read  out  1  Avalon read strobe.
REQ-014 jtag_write  out  1  Avalon write strobe.
REQ-015 jtag_writedata  out  32  {24'd0, byte}.
REQ-016 jtag_waitrequest  in  1  slave stall.
REQ-017 jtag_readdata  in  32  control: [31:16] WSPACE; data: [15] RVALID, [7:0] byte.

Function
REQ-018 Three-state FSM: POLL, WRITE, RDATA; exactly one strobe asserted in each state.
REQ-019 POLL: jtag_read=1, address 4; on !waitrequest, credit <= readdata[31:16].
REQ-020 POLL exit: WRITE if WSPACE!=0 and TX FIFO non-empty; else RDATA if ENABLE_RX and RX FIFO not full; else POLL.
REQ-021 WRITE: jtag_write=1, address 0, writedata = {24'd0, TX head}; on !waitrequest, pop TX and credit <= credit-1.
REQ-022 WRITE exit, evaluated on the accepting cycle: stay WRITE if credit-1!=0 and TX count after pop (incl. same-cycle push) !=0; else RDATA if ENABLE_RX and RX not full; else POLL.
REQ-023 RDATA: jtag_read=1, address 0; on !waitrequest, push readdata[7:0] into RX FIFO only if readdata[15]=1; next state POLL.
REQ-024 Read data sampled in the cycle read && !waitrequest; no extra latency.
REQ-025 Address, strobes and writedata held constant while waitrequest=1.
REQ-026 RDATA entered only when RX FIFO not full; no received byte is ever dropped.
REQ-027 Credit 16 bits; never decremented below 0; no write issued at credit 0.
REQ-028 TX FIFO: simultaneous push/pop when full is not possible (tx_ready=0); when empty, push only; count stays in range.
REQ-029 RX FIFO: simultaneous push and pop permitted at any fill level, including full (pop frees slot).
REQ-030 Byte accepted at cycle N is visible as TX head at N+1; bytes leave in acceptance order.
REQ-031 ENABLE_RX=0: RDATA unreachable, rx_valid tied 0, rx_ready ignored.

Reset
REQ-032 On reset: state POLL, credit 0, both FIFOs empty, jtag_write_data 0.
REQ-033 Outputs during/after reset cycle: jtag_read=1, jtag_address=4, jtag_write=0, jtag_writedata=0, tx_ready=1, rx_valid=0, rx_data=0.
REQ-034 Reset mid-transfer abandons the Avalon transaction and discards all buffered bytes.

Structure
REQ-035 Package jtag_uart_pkg holds state enum, address constants (CTRL=4, DATA=0), field positions WSPACE [31:16], RVALID bit 15.
REQ-036 One sub-module byte_fifo (parametrised depth, valid/ready both sides), instantiated for TX and RX.

Verification
REQ-037 Send 0x41,0x42,0x43; slave WSPACE=64, no stalls -> three writes 0x41,0x42,0x43 in order after one POLL, credit 61.
REQ-038 WSPACE=2, five bytes queued -> exactly 2 writes, then POLL; remaining 3 follow after next non-zero WSPACE.
REQ-039 waitrequest high 5 cycles during WRITE of 0x55 -> address/writedata stable throughout, single pop.
REQ-040 RDATA returns 0x00008061 then 0x00000000 -> rx_data=0x61 once; invalid read pushes nothing.
REQ-041 RX full (16 bytes), rx_ready=0 -> no RDATA issued; one pop -> next RDATA occurs.
REQ-042 Reset asserted while in WRITE with 4 bytes queued -> next cycle state POLL, tx_ready=1, rx_valid=0, no write strobe.
